// File: rtl/hazard_scoreboard.sv
// Per-register scoreboard hazard detector that sits beside the ID stage.
// Each register keeps two countdown timers. One counts down to register-file
// writeback. The other counts down to the point where the result can be forwarded.
module hazard_scoreboard #(
  parameter int unsigned REG_COUNT    = 16,
  parameter int unsigned REG_W        = 4,
  parameter int unsigned NUM_SRC      = 3,
  parameter int unsigned CNT_W        = 3,
  parameter int unsigned WB_LAT       = 2,
  parameter int unsigned ALU_FWD_LAT  = 0,
  parameter int unsigned LOAD_FWD_LAT = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       fwd_en,
  input  logic                       mem_freeze,
  input  logic                       issue_valid,
  input  logic                       issue_wb_en,
  input  logic                       issue_mem_r_en,
  input  logic [REG_W-1:0]           issue_dest,
  input  logic [NUM_SRC*REG_W-1:0]   src_addr,
  input  logic [NUM_SRC-1:0]         src_valid,
  output logic                       hazard_detected,
  output logic [NUM_SRC-1:0]         hazard_src,
  output logic [REG_COUNT-1:0]       pending_mask,
  output logic [15:0]                stall_count
);

  localparam int unsigned STALL_W = 16;
  localparam logic [STALL_W-1:0] STALL_MAX = '1;

  logic [CNT_W-1:0]     wb_cnt  [REG_COUNT];
  logic [CNT_W-1:0]     fwd_cnt [REG_COUNT];
  logic [REG_COUNT-1:0] fwd_pend;
  logic                 accept;

  // Per-register "not yet readable" and "not yet forwardable" flags
  always_comb begin
    pending_mask = '0;
    fwd_pend     = '0;
    for (int r = 0; r < REG_COUNT; r++) begin
      pending_mask[r] = (wb_cnt[r] != '0);
      fwd_pend[r]     = (fwd_cnt[r] != '0);
    end
  end

  // Source hazard lookup; addresses beyond REG_COUNT match no register and never flag
  always_comb begin
    hazard_src = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      for (int r = 0; r < REG_COUNT; r++) begin
        if (src_addr[i*REG_W +: REG_W] == REG_W'(r)) begin
          hazard_src[i] = src_valid[i] & (fwd_en ? fwd_pend[r] : pending_mask[r]);
        end
      end
    end
    hazard_detected = |hazard_src;
    accept          = issue_valid & issue_wb_en & ~hazard_detected & ~mem_freeze;
  end

  // Countdown timers; a newly accepted producer reloads its destination (newest producer wins)
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int r = 0; r < REG_COUNT; r++) begin
        wb_cnt[r]  <= '0;
        fwd_cnt[r] <= '0;
      end
    end else if (!mem_freeze) begin
      for (int r = 0; r < REG_COUNT; r++) begin
        if (accept && (issue_dest == REG_W'(r))) begin
          wb_cnt[r]  <= CNT_W'(WB_LAT);
          fwd_cnt[r] <= issue_mem_r_en ? CNT_W'(LOAD_FWD_LAT) : CNT_W'(ALU_FWD_LAT);
        end else begin
          if (wb_cnt[r] != '0) begin
            wb_cnt[r] <= wb_cnt[r] - CNT_W'(1);
          end
          if (fwd_cnt[r] != '0) begin
            fwd_cnt[r] <= fwd_cnt[r] - CNT_W'(1);
          end
        end
      end
    end
  end

  // Saturating count of cycles in which an ID instruction was held by a hazard
  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_count <= '0;
    end else if (!mem_freeze && issue_valid && hazard_detected && (stall_count != STALL_MAX)) begin
      stall_count <= stall_count + STALL_W'(1);
    end
  end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Parametrised, counter-based hazard detector for the in-order ARM pipeline; sits beside the ID stage.
- Replaces per-stage destination comparators with a per-register scoreboard. Each register has countdown timers to register-file writeback and to forwardability.
- Supports an arbitrary number of source operands, configurable load and ALU latencies, forwarding on/off, and a pipeline freeze for SRAM wait states.
- Provides per-source hazard flags and a stall statistics counter.

Parameters:
- REG_COUNT, 16, number of architectural registers tracked.
- REG_W, 4, register address width; REG_COUNT must be ≤ 2^REG_W.
- NUM_SRC, 3, number of source operand ports checked per cycle.
- CNT_W, 3, width of each per-register countdown counter.
- WB_LAT, 2, cycles from issue until the value is readable from the register file.
- ALU_FWD_LAT, 0, cycles from issue until an ALU result is forwardable.
- LOAD_FWD_LAT, 1, cycles from issue until a load result is forwardable.

Ports:
- clk  in  1  pipeline clock; all state updates on the rising edge.
- rst  in  1  synchronous active-low reset.
- fwd_en  in  1  1 = forwarding unit active (use forward counters); 0 = use writeback counters.
- mem_freeze  in  1  whole pipeline frozen (SRAM wait); scoreboard holds.
- issue_valid  in  1  an instruction is in ID this cycle.
- issue_wb_en  in  1  that instruction writes a register.
- issue_mem_r_en  in  1  that instruction is a load.
- issue_dest  in  REG_W  destination register of the ID instruction.
- src_addr  in  NUM_SRC*REG_W  source register addresses; source i occupies bits [i*REG_W +: REG_W].
- src_valid  in  NUM_SRC  source i is actually read (replaces two_src).
- hazard_detected  out  1  stall ID/IF and insert a bubble.
- hazard_src  out  NUM_SRC  per-source hazard flags.
- pending_mask  out  REG_COUNT  bit r = 1 when wb_cnt[r] != 0.
- stall_count  out  16  saturating count of hazard stall cycles.

Behaviour:
- State: for each register r, wb_cnt[r] and fwd_cnt[r] (each CNT_W bits), plus stall_count.
- Reset (rst = 0 at a clock edge): all counters and stall_count go to 0. With all counters 0, hazard_detected = 0, hazard_src = 0 and pending_mask = 0. Reset mid-operation discards all pending state immediately.
- Hazard logic (combinational from current state, zero latency):
  - hazard_src[i] = src_valid[i] & (fwd_en ? fwd_cnt[src_i] != 0 : wb_cnt[src_i] != 0).
  - hazard_detected = OR of hazard_src.
  - Source addresses ≥ REG_COUNT never flag a hazard.
- Issue acceptance: accept = issue_valid & issue_wb_en & !hazard_detected & !mem_freeze.
- Counter update per edge when mem_freeze = 0:
  - Every nonzero counter decrements by 1; counters at 0 stay at 0.
  - If accept: wb_cnt[issue_dest] <= WB_LAT. fwd_cnt[issue_dest] <= issue_mem_r_en ? LOAD_FWD_LAT : ALU_FWD_LAT.
  - The accept load overrides the decrement for that register (write-after-write: the newest producer wins).
  - issue_dest ≥ REG_COUNT is ignored.
- mem_freeze = 1: all counters hold; no accept; stall_count holds. Outputs are still driven from the held state.
- Self-dependency (e.g. ADD r1,r1,#1): the hazard check uses pre-update state, so an instruction never stalls on itself.
- A stalled instruction (hazard_detected = 1) is not recorded. Its counters load on the cycle it is finally accepted.
- stall_count increments when issue_valid & hazard_detected & !mem_freeze, and saturates at 16'hFFFF with no wrap.
- Defaults reproduce the classic 5-stage behaviour:
  - Without forwarding, a consumer stalls while the producer is in EXE or MEM.
  - With forwarding, a consumer stalls only when a load is in EXE.
- Legal configuration: ALU_FWD_LAT ≤ WB_LAT; LOAD_FWD_LAT ≤ WB_LAT; WB_LAT < 2^CNT_W. Out-of-range values are illegal configurations.

Test Plan:
- Reset, fwd_en = 0: issue ADD r3 (wb_en), then a consumer with src0 = r3 valid on the following cycles → hazard_detected = 1 for exactly 2 cycles, then 0; pending_mask[3] sequence 1,1,0; stall_count = 2.
- fwd_en = 1: ALU writer to r5 followed by a reader of r5 → no stall. Load to r5 followed by a reader → exactly 1 stall cycle, hazard_src = 3'b001.
- Reader with src1 = r2 while src_valid[1] = 0 and r2 pending → hazard_detected = 0. Same case with src_valid[1] = 1 → hazard_src = 3'b010.
- Load to r4, then mem_freeze = 1 for 3 cycles → fwd_cnt[4] holds at 1 and hazard stays asserted throughout; it clears one cycle after freeze drops. stall_count does not advance during the freeze.
- Back-to-back writers to r7 (second issued 1 cycle later, no dependency) → pending_mask[7] stays 1 for 3 cycles total; counters reload to WB_LAT on the second issue.
- Force 70000 hazard cycles → stall_count = 16'hFFFF. Assert rst = 0 mid-stall → next cycle all outputs are 0.
